// File: rtl/top_terms_bus_arbiter_if.sv
// top_terms_bus_arbiter_if: request/grant and shared-bus signals of the round-robin bus arbiter
interface top_terms_bus_arbiter_if #(
  parameter int NREQ = 4,
  parameter int WIDTH = 32
);
  logic [NREQ-1:0] req;
  logic [NREQ-1:0] last;
  logic [NREQ-1:0] gnt;
  logic [NREQ*WIDTH-1:0] data;
  logic [WIDTH-1:0] bus_data;
  logic bus_valid;
  logic bus_last;
  logic bus_ready;
  logic busy;
  modport master(output req, last, data, bus_ready, input gnt, bus_data, bus_valid, bus_last, busy);
  modport slave(input req, last, data, bus_ready, output gnt, bus_data, bus_valid, bus_last, busy);
endinterface

// File: rtl/top_terms_bus_arbiter.sv
// top_terms_bus_arbiter: round-robin arbiter granting locked bursts of up to MAXBEATS beats on a shared bus
module top_terms_bus_arbiter #(
  parameter int NREQ = 4,
  parameter int WIDTH = 32,
  parameter int MAXBEATS = 16
) (
  input logic clk,
  input logic rst_n,
  top_terms_bus_arbiter_if.slave bus
);
  localparam int IW = $clog2(NREQ);
  typedef enum logic {IDLE, XFER} state_t;
  state_t state;
  state_t state_d;
  logic [NREQ-1:0] gnt_q;
  logic [IW-1:0] g;
  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] win;
  logic [7:0] beat_cnt;
  logic valid;
  logic fin;
  logic done;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      gnt_q <= '0;
      g <= '0;
      rr_ptr <= '0;
      beat_cnt <= '0;
    end else begin
      state <= state_d;
      if (state == IDLE && |bus.req) begin
        gnt_q <= NREQ'(1) << win;
        g <= win;
      end
      if (done) begin
        gnt_q <= '0;
        beat_cnt <= '0;
        rr_ptr <= (int'(g) == NREQ - 1) ? '0 : g + 1'b1;
      end else if (valid && bus.bus_ready) begin
        beat_cnt <= beat_cnt + 8'd1;
      end
    end
  end
  always_comb begin
    win = '0;
    for (int k = NREQ - 1; k >= 0; k--)
      if (bus.req[(int'(rr_ptr) + k) % NREQ]) win = IW'((int'(rr_ptr) + k) % NREQ);
    state_d = (state == IDLE) ? (|bus.req ? XFER : IDLE) : (done ? IDLE : XFER);
  end
  always_comb begin
    valid = (state == XFER) && bus.req[g];
    fin = valid && (bus.last[g] || beat_cnt == 8'(MAXBEATS - 1));
    done = fin && bus.bus_ready;
    bus.gnt = gnt_q;
    bus.busy = state == XFER;
    bus.bus_valid = valid;
    bus.bus_last = fin;
    bus.bus_data = (state == XFER) ? bus.data[int'(g)*WIDTH +: WIDTH] : '0;
  end
endmodule
